tdpram_wide_narrow: RTL and testbench



---
 rtl/tdpram_wide_narrow_if.sv | 43 ++++
 rtl/tdpram_wide_narrow.sv | 223 ++++++++++++++++++++++
 tb/tb_tdpram_wide_narrow.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tdpram_wide_narrow_if.sv
// Bus bundle for tdpram_wide_narrow: one wide (32*LANES bit) port and one
// narrow (32 bit) port, each with write/read strobes, byte enables and a
// single-cycle rvalid pulse, plus the shared ready indication.
interface tdpram_wide_narrow_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int LANES      = 2
);
    localparam int LANE_BITS = $clog2(LANES);

    logic                          ready;

    logic                          we_w;
    logic                          rd_w;
    logic [4*LANES-1:0]            byte_en_w;
    logic [ADDR_WIDTH-1:0]         addr_w;
    logic [32*LANES-1:0]           wdata_w;
    logic [32*LANES-1:0]           rdata_w;
    logic                          rvalid_w;

    logic                          we_n;
    logic                          rd_n;
    logic [3:0]                    byte_en_n;
    logic [ADDR_WIDTH+LANE_BITS-1:0] addr_n;
    logic [31:0]                   wdata_n;
    logic [31:0]                   rdata_n;
    logic                          rvalid_n;

    modport master (
        input  ready,
        output we_w, rd_w, byte_en_w, addr_w, wdata_w,
        input  rdata_w, rvalid_w,
        output we_n, rd_n, byte_en_n, addr_n, wdata_n,
        input  rdata_n, rvalid_n
    );

    modport slave (
        output ready,
        input  we_w, rd_w, byte_en_w, addr_w, wdata_w,
        output rdata_w, rvalid_w,
        input  we_n, rd_n, byte_en_n, addr_n, wdata_n,
        output rdata_n, rvalid_n
    );
endinterface

// File: rtl/tdpram_wide_narrow.sv
// Wide/narrow true dual-port RAM used as tightly-coupled memory.
// Port W accesses a whole 32*LANES word, port N one 32-bit lane of it
// (big-endian: narrow offset 0 is the most significant lane).
// Read latency 1, write-first on both ports, W wins overlapping bytes on a
// same-word write collision, and reads see the post-collision word via a
// registered bypass.
// Optional build macro TDPRAM_INIT_CLEAR_EN: INIT zeroes every word, one per
// cycle, before ready rises; without it INIT lasts a single cycle and the
// contents survive reset.
module tdpram_wide_narrow #(
    parameter int ADDR_WIDTH = 13,
    parameter int LANES      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tdpram_wide_narrow_if.slave   bus
);
    localparam int LANE_BITS = $clog2(LANES);
    localparam int WB        = 4 * LANES;
    localparam int DW        = 32 * LANES;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    generate
        if (!(LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
            $error("tdpram_wide_narrow: LANES must be 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [DW-1:0]          mem_r [DEPTH];

`ifdef TDPRAM_INIT_CLEAR_EN
    logic [ADDR_WIDTH-1:0]  clr_cnt_r;
    logic [ADDR_WIDTH-1:0]  clr_cnt_nxt_s;
    logic                   clr_we_s;
`endif

    logic                   accept_s;
    logic                   wr_w_s;
    logic                   rd_w_s;
    logic                   wr_n_s;
    logic                   rd_n_s;
    logic [ADDR_WIDTH-1:0]  word_n_s;
    logic [LANE_BITS-1:0]   lane_n_s;
    logic [WB-1:0]          be_n_wide_s;
    logic [DW-1:0]          data_n_wide_s;
    logic                   coll_s;
    logic [WB-1:0]          be_w_eff_s;
    logic [WB-1:0]          be_n_eff_s;
    logic [DW-1:0]          rd_full_w_s;
    logic [DW-1:0]          rd_full_n_s;
    logic [31:0]            rd_lane_n_s;

    logic [DW-1:0]          rdata_w_r;
    logic                   rvalid_w_r;
    logic [31:0]            rdata_n_r;
    logic                   rvalid_n_r;

    // Byte-wise merge of pending writes onto a stored word; W bytes take
    // precedence over N bytes, untouched bytes keep the stored value.
    function automatic logic [DW-1:0] merge_word(
        input logic [DW-1:0] base,
        input logic [WB-1:0] be_w,
        input logic [DW-1:0] d_w,
        input logic [WB-1:0] be_n,
        input logic [DW-1:0] d_n
    );
        logic [DW-1:0] res;
        for (int i = 0; i < WB; i++) begin
            if (be_w[i]) begin
                res[8*i +: 8] = d_w[8*i +: 8];
            end else if (be_n[i]) begin
                res[8*i +: 8] = d_n[8*i +: 8];
            end else begin
                res[8*i +: 8] = base[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Requests are honoured only in RUN and never on a reset edge.
    assign accept_s      = rst_n & (state_r == ST_RUN);
    assign wr_w_s        = bus.we_w & accept_s;
    assign rd_w_s        = bus.rd_w & accept_s;
    assign wr_n_s        = bus.we_n & accept_s;
    assign rd_n_s        = bus.rd_n & accept_s;

    // Big-endian lane select: lane = LANES-1-offset, which is ~offset.
    assign word_n_s      = bus.addr_n[ADDR_WIDTH+LANE_BITS-1:LANE_BITS];
    assign lane_n_s      = ~bus.addr_n[LANE_BITS-1:0];
    assign be_n_wide_s   = {{(WB-4){1'b0}}, bus.byte_en_n} << {lane_n_s, 2'b00};
    assign data_n_wide_s = {LANES{bus.wdata_n}};
    assign coll_s        = wr_w_s & wr_n_s & (bus.addr_w == word_n_s);

    // Effective byte enables: N loses any byte that W also writes this cycle.
    always_comb begin
        be_w_eff_s = '0;
        be_n_eff_s = '0;
        if (wr_w_s) begin
            be_w_eff_s = bus.byte_en_w;
        end else begin
            be_w_eff_s = '0;
        end
        if (wr_n_s) begin
            be_n_eff_s = be_n_wide_s;
        end else begin
            be_n_eff_s = '0;
        end
        if (coll_s) begin
            be_n_eff_s = be_n_eff_s & ~bus.byte_en_w;
        end else begin
            be_n_eff_s = be_n_eff_s;
        end
    end

    // Write-first read data for both ports, including same-cycle writes
    // from either port to the word being read.
    always_comb begin
        rd_full_w_s = merge_word(mem_r[bus.addr_w],
                                 be_w_eff_s, bus.wdata_w,
                                 (word_n_s == bus.addr_w) ? be_n_eff_s : {WB{1'b0}},
                                 data_n_wide_s);
        rd_full_n_s = merge_word(mem_r[word_n_s],
                                 (bus.addr_w == word_n_s) ? be_w_eff_s : {WB{1'b0}},
                                 bus.wdata_w,
                                 be_n_eff_s, data_n_wide_s);
        rd_lane_n_s = rd_full_n_s[{lane_n_s, 5'b00000} +: 32];
    end

    // Memory array: user byte writes, plus the INIT clear walk when built in.
    always_ff @(posedge clk) begin
`ifdef TDPRAM_INIT_CLEAR_EN
        if (clr_we_s) begin
            mem_r[clr_cnt_r] <= '0;
        end
`endif
        for (int i = 0; i < WB; i++) begin
            if (be_w_eff_s[i]) begin
                mem_r[bus.addr_w][8*i +: 8] <= bus.wdata_w[8*i +: 8];
            end
            if (be_n_eff_s[i]) begin
                mem_r[word_n_s][8*i +: 8] <= data_n_wide_s[8*i +: 8];
            end
        end
    end

    // FSM state register (and clear counter), synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_INIT;
`ifdef TDPRAM_INIT_CLEAR_EN
            clr_cnt_r <= '0;
`endif
        end else begin
            state_r   <= state_nxt_s;
`ifdef TDPRAM_INIT_CLEAR_EN
            clr_cnt_r <= clr_cnt_nxt_s;
`endif
        end
    end

    // FSM next state: INIT either walks the clear counter or lasts one cycle.
    always_comb begin
        state_nxt_s = state_r;
`ifdef TDPRAM_INIT_CLEAR_EN
        clr_we_s      = 1'b0;
        clr_cnt_nxt_s = clr_cnt_r;
`endif
        case (state_r)
            ST_INIT: begin
`ifdef TDPRAM_INIT_CLEAR_EN
                clr_we_s      = rst_n;
                clr_cnt_nxt_s = clr_cnt_r + ADDR_WIDTH'(1);
                if (clr_cnt_r == {ADDR_WIDTH{1'b1}}) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
`else
                state_nxt_s = ST_RUN;
`endif
            end
            ST_RUN: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s = ST_INIT;
            end
        endcase
    end

    // Read output registers: rvalid pulses per read, rdata holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_w_r  <= '0;
            rvalid_w_r <= 1'b0;
            rdata_n_r  <= '0;
            rvalid_n_r <= 1'b0;
        end else begin
            rvalid_w_r <= rd_w_s;
            rvalid_n_r <= rd_n_s;
            if (rd_w_s) begin
                rdata_w_r <= rd_full_w_s;
            end
            if (rd_n_s) begin
                rdata_n_r <= rd_lane_n_s;
            end
        end
    end

    assign bus.ready    = (state_r == ST_RUN);
    assign bus.rdata_w  = rdata_w_r;
    assign bus.rvalid_w = rvalid_w_r;
    assign bus.rdata_n  = rdata_n_r;
    assign bus.rvalid_n = rvalid_n_r;

endmodule

// File: tb/tb_tdpram_wide_narrow.sv
// Self-checking bench for tdpram_wide_narrow. Two instances (LANES=4 and
// LANES=2, ADDR_WIDTH=4) are driven from one directed sequence; a model that
// stores memory as 32-bit entries indexed by narrow address predicts every
// output after every clock edge, and literal expectations pin the model.
module tb_tdpram_wide_narrow;
    localparam int AW = 4;
`ifdef TDPRAM_INIT_CLEAR_EN
    localparam int INIT_CYC = 16;
    localparam bit CLR      = 1'b1;
`else
    localparam int INIT_CYC = 1;
    localparam bit CLR      = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tdpram_wide_narrow_if #(.ADDR_WIDTH(AW), .LANES(4)) if4 ();
    tdpram_wide_narrow_if #(.ADDR_WIDTH(AW), .LANES(2)) if2 ();

    tdpram_wide_narrow #(.ADDR_WIDTH(AW), .LANES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    tdpram_wide_narrow #(.ADDR_WIDTH(AW), .LANES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    // Stimulus shared by both instances; only the selected one sees strobes.
    int           cur;
    logic         t_we_w, t_rd_w, t_we_n, t_rd_n;
    logic [15:0]  t_be_w;
    logic [3:0]   t_be_n;
    logic [3:0]   t_addr_w;
    logic [5:0]   t_addr_n;
    logic [127:0] t_wd_w;
    logic [31:0]  t_wd_n;

    assign if4.we_w      = (cur == 0) & t_we_w;
    assign if4.rd_w      = (cur == 0) & t_rd_w;
    assign if4.we_n      = (cur == 0) & t_we_n;
    assign if4.rd_n      = (cur == 0) & t_rd_n;
    assign if4.byte_en_w = t_be_w;
    assign if4.addr_w    = t_addr_w;
    assign if4.wdata_w   = t_wd_w;
    assign if4.byte_en_n = t_be_n;
    assign if4.addr_n    = t_addr_n;
    assign if4.wdata_n   = t_wd_n;

    assign if2.we_w      = (cur == 1) & t_we_w;
    assign if2.rd_w      = (cur == 1) & t_rd_w;
    assign if2.we_n      = (cur == 1) & t_we_n;
    assign if2.rd_n      = (cur == 1) & t_rd_n;
    assign if2.byte_en_w = t_be_w[7:0];
    assign if2.addr_w    = t_addr_w;
    assign if2.wdata_w   = t_wd_w[63:0];
    assign if2.byte_en_n = t_be_n;
    assign if2.addr_n    = t_addr_n[4:0];
    assign if2.wdata_n   = t_wd_n;

    // Model state, index 0 = LANES 4, index 1 = LANES 2.
    logic [31:0]  nm [2][64];
    int           rel [2];
    bit           mrdy [2];
    logic [127:0] e_rdw [2];
    logic [31:0]  e_rdn [2];
    bit           e_rvw [2];
    bit           e_rvn [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Predict the effect of the coming edge from the currently driven inputs.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int L;
            int na;
            bit acc;
            L   = (k == 0) ? 4 : 2;
            na  = int'(t_addr_n) % (16 * L);
            acc = rst_n && mrdy[k];
            if (!rst_n) begin
                rel[k]   = 0;
                e_rdw[k] = '0;
                e_rdn[k] = '0;
                e_rvw[k] = 1'b0;
                e_rvn[k] = 1'b0;
            end else begin
                e_rvw[k] = 1'b0;
                e_rvn[k] = 1'b0;
                if (CLR && !mrdy[k]) begin
                    for (int j = 0; j < L; j++) nm[k][rel[k]*L + j] = '0;
                end
                if (acc && k == cur) begin
                    // N first, then W on top: W owns any byte both write.
                    if (t_we_n) begin
                        for (int b = 0; b < 4; b++)
                            if (t_be_n[b]) nm[k][na][8*b +: 8] = t_wd_n[8*b +: 8];
                    end
                    if (t_we_w) begin
                        for (int ln = 0; ln < L; ln++)
                            for (int b = 0; b < 4; b++)
                                if (t_be_w[4*ln + b])
                                    nm[k][int'(t_addr_w)*L + L-1-ln][8*b +: 8] = t_wd_w[32*ln + 8*b +: 8];
                    end
                    if (t_rd_w) begin
                        e_rdw[k] = '0;
                        for (int ln = 0; ln < L; ln++)
                            e_rdw[k][32*ln +: 32] = nm[k][int'(t_addr_w)*L + L-1-ln];
                        e_rvw[k] = 1'b1;
                    end
                    if (t_rd_n) begin
                        e_rdn[k] = nm[k][na];
                        e_rvn[k] = 1'b1;
                    end
                end
                if (rel[k] < 1000) rel[k]++;
            end
            mrdy[k] = (rel[k] >= INIT_CYC);
        end
    endtask

    // One clock: model, edge, then compare every output of both instances.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("ready4",    if4.ready,    mrdy[0]);
        chk("rvalid_w4", if4.rvalid_w, e_rvw[0]);
        chk("rvalid_n4", if4.rvalid_n, e_rvn[0]);
        chk("rdata_w4",  if4.rdata_w,  e_rdw[0]);
        chk("rdata_n4",  if4.rdata_n,  e_rdn[0]);
        chk("ready2",    if2.ready,    mrdy[1]);
        chk("rvalid_w2", if2.rvalid_w, e_rvw[1]);
        chk("rvalid_n2", if2.rvalid_n, e_rvn[1]);
        chk("rdata_w2",  if2.rdata_w,  e_rdw[1][63:0]);
        chk("rdata_n2",  if2.rdata_n,  e_rdn[1]);
    endtask

    task automatic op(input int k,
                      input bit we_w, input bit rd_w, input logic [3:0] aw,
                      input logic [15:0] bew, input logic [127:0] dw,
                      input bit we_n, input bit rd_n, input logic [5:0] an,
                      input logic [3:0] ben, input logic [31:0] dn);
        cur = k;
        t_we_w = we_w; t_rd_w = rd_w; t_addr_w = aw; t_be_w = bew; t_wd_w = dw;
        t_we_n = we_n; t_rd_n = rd_n; t_addr_n = an; t_be_n = ben; t_wd_n = dn;
        step();
        t_we_w = 1'b0; t_rd_w = 1'b0; t_we_n = 1'b0; t_rd_n = 1'b0;
    endtask

    logic [31:0] lane_exp [4] = '{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    initial begin
        cur = 0;
        t_we_w = 1'b0; t_rd_w = 1'b0; t_we_n = 1'b0; t_rd_n = 1'b0;
        t_be_w = '0; t_be_n = '0; t_addr_w = '0; t_addr_n = '0; t_wd_w = '0; t_wd_n = '0;
        for (int k = 0; k < 2; k++) begin
            rel[k] = 0; mrdy[k] = 1'b0; e_rdw[k] = '0; e_rdn[k] = '0;
            e_rvw[k] = 1'b0; e_rvn[k] = 1'b0;
            for (int a = 0; a < 64; a++) nm[k][a] = '0;
        end

        // Reset held for 3 cycles, with strobes asserted to show they are ignored.
        rst_n = 1'b0;
        t_rd_w = 1'b1; t_rd_n = 1'b1;
        repeat (3) step();
        chk("rst_ready_lit", if4.ready, 1'b0);
        chk("rst_rvalid_lit", if4.rvalid_n, 1'b0);
        t_rd_w = 1'b0; t_rd_n = 1'b0;
        rst_n = 1'b1;
        repeat (INIT_CYC) step();
        chk("ready_up_lit", if4.ready, 1'b1);

        // Bring both memories to a known all-zero state.
        for (int w = 0; w < 16; w++) begin
            op(0, 1'b1, 1'b0, 4'(w), 16'hFFFF, '0, 1'b0, 1'b0, '0, '0, '0);
            op(1, 1'b1, 1'b0, 4'(w), 16'h00FF, '0, 1'b0, 1'b0, '0, '0, '0);
        end

        // Big-endian lane mapping on LANES=4.
        op(0, 1'b1, 1'b0, 4'd5, 16'hFFFF, 128'h44444444_33333333_22222222_11111111,
           1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            op(0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 6'(20 + i), '0, '0);
            chk("lane_map_lit", if4.rdata_n, lane_exp[i]);
            chk("lane_rvalid_lit", if4.rvalid_n, 1'b1);
        end
        step();
        chk("rvalid_pulse_lit", if4.rvalid_n, 1'b0);
        chk("rdata_hold_lit", if4.rdata_n, 32'h11111111);

        // All-zero byte enable write is a no-op; read back same cycle.
        op(0, 1'b1, 1'b1, 4'd5, 16'h0000, {128{1'b1}}, 1'b0, 1'b0, '0, '0, '0);
        chk("be_zero_lit", if4.rdata_w, 128'h44444444_33333333_22222222_11111111);

        // Same-port write+read (write-first) on both ports of LANES=4.
        op(0, 1'b1, 1'b1, 4'd7, 16'h00F0, 128'h01234567_89ABCDEF_0F1E2D3C_4B5A6978,
           1'b1, 1'b1, 6'd30, 4'h3, 32'hCAFEF00D);
        // Cross-port: narrow read of a word the wide port writes this cycle.
        op(0, 1'b1, 1'b0, 4'd2, 16'hF0F0, 128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4,
           1'b0, 1'b1, 6'd8, '0, '0);
        chk("fwd_n_lit", if4.rdata_n, 32'hA1A2A3A4);

        // Write collision on LANES=2: W owns all of lane 0.
        op(1, 1'b1, 1'b0, 4'd3, 16'h000F, 128'hAAAAAAAA_AAAAAAAA,
           1'b1, 1'b0, 6'd7, 4'hF, 32'h55555555);
        op(1, 1'b0, 1'b1, 4'd3, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        chk("coll_w_lit", if2.rdata_w, 128'h00000000_AAAAAAAA);
        op(1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 6'd6, '0, '0);
        chk("coll_n_lit", if2.rdata_n, 32'h00000000);
        // Partial overlap collision: N keeps its non-overlapping bytes.
        op(1, 1'b1, 1'b0, 4'd4, 16'h0003, 128'h11111111_22222222,
           1'b1, 1'b0, 6'd9, 4'hF, 32'h99999999);
        op(1, 1'b0, 1'b1, 4'd4, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        chk("coll_part_lit", if2.rdata_w, 128'h00000000_99992222);

        // Cross-port forwarding on LANES=2.
        op(1, 1'b0, 1'b1, 4'd9, '0, '0, 1'b1, 1'b0, 6'd18, 4'hC, 32'hDEADBEEF);
        chk("fwd_w_lit", if2.rdata_w[63:32], 32'hDEAD0000);

        // Fill LANES=4 with ones, reset, poke during INIT, reset again mid-INIT.
        for (int a = 0; a < 64; a++)
            op(0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 6'(a), 4'hF, 32'hFFFFFFFF);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++)
            op(0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 6'(i), 4'hF, 32'h12345678);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < INIT_CYC + 2; i++)
            op(0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 6'(40 + i), 4'hF, 32'h0BADF00D);
        for (int w = 0; w < 16; w++) begin
            op(0, 1'b0, 1'b1, 4'(w), '0, '0, 1'b0, 1'b0, '0, '0, '0);
            op(1, 1'b0, 1'b1, 4'(w), '0, '0, 1'b0, 1'b0, '0, '0, '0);
        end
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
